// File: rtl/seq_mul_if.sv
// Request/response bundle between the EX-stage controller (master) and the
// iterative multiplier (slave).
interface seq_mul_if #(
   parameter int WIDTH = 32
);
   logic             mul_start;
   logic             mul_signed;
   logic             mul_flush;
   logic [WIDTH-1:0] mul_src1;
   logic [WIDTH-1:0] mul_src2;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_result_l;
   logic [WIDTH-1:0] mul_result_h;

   modport master (
      output mul_start, mul_signed, mul_flush, mul_src1, mul_src2,
      input  mul_busy, mul_done, mul_result_l, mul_result_h
   );

   modport slave (
      input  mul_start, mul_signed, mul_flush, mul_src1, mul_src2,
      output mul_busy, mul_done, mul_result_l, mul_result_h
   );
endinterface

// File: rtl/seq_mul.sv
// Shift-and-add multiplier for MULT/MULTU: WIDTH iterations on magnitudes,
// sign applied once on the CALC->DONE edge into the HI/LO result registers.
module seq_mul #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   seq_mul_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state, state_nx;
   logic [2*WIDTH-1:0] mcand, acc, acc_sum, prod;
   logic [WIDTH-1:0]   mplier, abs1, abs2;
   logic [CW-1:0]      cnt;
   logic               neg, accept, last;

   assign accept = (state != CALC) && bus.mul_start && !bus.mul_flush;
   assign last   = (cnt == CW'(WIDTH-1));

   // Two's-complement negate of the most-negative value yields 2^(WIDTH-1) unsigned.
   assign abs1 = (bus.mul_signed && bus.mul_src1[WIDTH-1]) ? (~bus.mul_src1 + WIDTH'(1)) : bus.mul_src1;
   assign abs2 = (bus.mul_signed && bus.mul_src2[WIDTH-1]) ? (~bus.mul_src2 + WIDTH'(1)) : bus.mul_src2;

   assign acc_sum = acc + (mplier[0] ? mcand : '0);
   assign prod    = neg ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = accept ? CALC : IDLE;
         CALC: begin
            if (bus.mul_flush) state_nx = IDLE;
            else if (last)     state_nx = DONE;
            else               state_nx = CALC;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.mul_busy = (state == CALC);
      bus.mul_done = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand            <= '0;
         mplier           <= '0;
         acc              <= '0;
         cnt              <= '0;
         neg              <= 1'b0;
         bus.mul_result_l <= '0;
         bus.mul_result_h <= '0;
      end else if (accept) begin
         mcand  <= {{WIDTH{1'b0}}, abs1};
         mplier <= abs2;
         neg    <= bus.mul_signed & (bus.mul_src1[WIDTH-1] ^ bus.mul_src2[WIDTH-1]);
         acc    <= '0;
         cnt    <= '0;
      end else if (state == CALC && !bus.mul_flush) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (last) begin
            bus.mul_result_l <= prod[WIDTH-1:0];
            bus.mul_result_h <= prod[2*WIDTH-1:WIDTH];
         end
      end
   end
endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul at WIDTH=32 and WIDTH=8: expected products are
// queued at issue and compared whenever a done pulse is observed.
module tb_seq_mul;
   logic clk, rst;
   int   n_vec, n_err;
   logic [63:0] q32[$];
   logic [63:0] q8[$];
   int   lat, bsy;

   seq_mul_if #(.WIDTH(32)) bus32();
   seq_mul_if #(.WIDTH(8))  bus8();

   seq_mul #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   seq_mul #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] av, bv, p;
      logic [63:0] m;
      av = '0; bv = '0;
      av[31:0] = a; bv[31:0] = b;
      if (w < 32) begin
         av = av & ((64'sd1 <<< w) - 1);
         bv = bv & ((64'sd1 <<< w) - 1);
      end
      if (s && a[w-1]) av = av - (64'sd1 <<< w);
      if (s && b[w-1]) bv = bv - (64'sd1 <<< w);
      p = av * bv;
      m = (w == 32) ? '1 : ((64'd1 << (2*w)) - 1);
      return p & m;
   endfunction

   // Scoreboards
   always @(negedge clk) begin
      if (!rst && bus32.mul_done) begin
         if (q32.size() == 0) chk("done32_unexpected", {63'b0, bus32.mul_done}, 64'd0);
         else chk("result32", {bus32.mul_result_h, bus32.mul_result_l}, q32.pop_front());
      end
      if (!rst && bus8.mul_done) begin
         if (q8.size() == 0) chk("done8_unexpected", {63'b0, bus8.mul_done}, 64'd0);
         else chk("result8", {48'b0, bus8.mul_result_h, bus8.mul_result_l}, q8.pop_front());
      end
   end

   task automatic drive(input bit w8, input bit s, input logic [31:0] a, input logic [31:0] b, input bit push);
      if (w8) begin
         bus8.mul_start = 1'b1; bus8.mul_signed = s;
         bus8.mul_src1 = a[7:0]; bus8.mul_src2 = b[7:0];
         if (push) q8.push_back(model(8, s, a, b));
      end else begin
         bus32.mul_start = 1'b1; bus32.mul_signed = s;
         bus32.mul_src1 = a; bus32.mul_src2 = b;
         if (push) q32.push_back(model(32, s, a, b));
      end
   endtask

   task automatic release_start();
      @(posedge clk); #1;
      bus32.mul_start = 1'b0;
      bus8.mul_start  = 1'b0;
   endtask

   task automatic issue(input bit w8, input bit s, input logic [31:0] a, input logic [31:0] b, input bit push);
      @(posedge clk); #1;
      drive(w8, s, a, b, push);
      release_start();
   endtask

   // Counts negedges after the sampling edge until done; lat=-1 on timeout.
   task automatic wait_done(input bit w8, input int budget, output int l, output int b);
      l = -1; b = 0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (w8 ? bus8.mul_busy : bus32.mul_busy) b++;
         if (w8 ? bus8.mul_done : bus32.mul_done) begin
            l = c;
            break;
         end
      end
      if (l < 0) chk("done_timeout", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1;
      bus32.mul_start = 0; bus32.mul_signed = 0; bus32.mul_flush = 0; bus32.mul_src1 = 0; bus32.mul_src2 = 0;
      bus8.mul_start  = 0; bus8.mul_signed  = 0; bus8.mul_flush  = 0; bus8.mul_src1  = 0; bus8.mul_src2  = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {63'b0, bus32.mul_busy}, 64'd0);
      chk("rst_done", {63'b0, bus32.mul_done}, 64'd0);
      chk("rst_result", {bus32.mul_result_h, bus32.mul_result_l}, 64'd0);
      rst = 1'b0;

      // Basic unsigned, latency and busy width
      issue(0, 0, 3, 5, 1);
      wait_done(0, 100, lat, bsy);
      chk("lat_3x5", 64'(lat), 64'd33);
      chk("busy_3x5", 64'(bsy), 64'd32);

      issue(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_done(0, 100, lat, bsy);
      issue(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_done(0, 100, lat, bsy);
      issue(0, 1, 32'h8000_0000, 32'h8000_0000, 1); wait_done(0, 100, lat, bsy);
      chk("hi_minxmin", {32'b0, bus32.mul_result_h}, 64'h4000_0000);
      issue(0, 1, 32'hFFFF_FFFD, 32'd7, 1);         wait_done(0, 100, lat, bsy);
      chk("lo_m3x7", {32'b0, bus32.mul_result_l}, 64'hFFFF_FFEB);
      issue(0, 1, 32'd0, 32'h8000_0000, 1);         wait_done(0, 100, lat, bsy);

      // Ignored start while busy, then back-to-back start in DONE
      issue(0, 0, 6, 7, 1);
      repeat (9) @(negedge clk);
      drive(0, 0, 2, 2, 0);
      release_start();
      wait_done(0, 100, lat, bsy);
      drive(0, 0, 9, 9, 1);
      release_start();
      wait_done(0, 100, lat, bsy);
      chk("lat_b2b", 64'(lat), 64'd33);
      chk("lo_b2b", {32'b0, bus32.mul_result_l}, 64'd81);

      // Flush mid-operation
      issue(0, 0, 100, 100, 0);
      repeat (15) @(negedge clk);
      bus32.mul_flush = 1'b1;
      @(posedge clk); #1;
      bus32.mul_flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", {63'b0, bus32.mul_busy}, 64'd0);
      // Flush together with start in IDLE: start must be dropped
      @(posedge clk); #1;
      bus32.mul_flush = 1'b1;
      drive(0, 0, 5, 5, 0);
      release_start();
      bus32.mul_flush = 1'b0;
      @(negedge clk);
      chk("flush_start_busy", {63'b0, bus32.mul_busy}, 64'd0);
      repeat (40) @(negedge clk);
      chk("flush_hold", {bus32.mul_result_h, bus32.mul_result_l}, 64'd81);
      issue(0, 0, 4, 4, 1); wait_done(0, 100, lat, bsy);
      chk("lat_4x4", 64'(lat), 64'd33);

      // Async reset mid-operation
      issue(0, 0, 1234, 5678, 0);
      repeat (20) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {63'b0, bus32.mul_busy}, 64'd0);
      chk("arst_done", {63'b0, bus32.mul_done}, 64'd0);
      chk("arst_result", {bus32.mul_result_h, bus32.mul_result_l}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      issue(0, 0, 2, 3, 1); wait_done(0, 100, lat, bsy);
      chk("lat_2x3", 64'(lat), 64'd33);

      // WIDTH=8 instance
      issue(1, 0, 3, 5, 1);
      wait_done(1, 40, lat, bsy);
      chk("lat8_3x5", 64'(lat), 64'd9);
      chk("busy8_3x5", 64'(bsy), 64'd8);
      issue(1, 0, 8'hFF, 8'hFF, 1); wait_done(1, 40, lat, bsy);
      issue(1, 1, 8'hFF, 8'hFF, 1); wait_done(1, 40, lat, bsy);
      issue(1, 1, 8'h80, 8'h80, 1); wait_done(1, 40, lat, bsy);
      chk("hi8_minxmin", {56'b0, bus8.mul_result_h}, 64'h40);
      issue(1, 1, 8'hFD, 8'h07, 1); wait_done(1, 40, lat, bsy);

      repeat (5) @(negedge clk);
      chk("q32_drain", 64'(q32.size()), 64'd0);
      chk("q8_drain", 64'(q8.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
